// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with flush abort and a one-cycle done pulse.
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] oper1_i,
  input  logic [WIDTH-1:0] oper2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     sum, rem_shift, diff;
  logic               accept, div_zero, last;

  assign accept   = (state == IDLE) && start_i && !flush_i;
  assign div_zero = op_i[1] && (oper2_i == '0);
  assign last     = (count == LAST);

  assign ready_o = (state == IDLE);
  assign stall_o = accept || (state == RUN);
  assign done_o  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_zero ? DONE : RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // acc holds {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend/quotient bits} for divide.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    acc_step  = acc;
    if (!op_q[1]) begin
      if (acc[0]) acc_step = {sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op_q     <= '0;
      operand  <= '0;
      acc      <= '0;
      result_o <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q  <= op_i;
            count <= '0;
            if (op_i[1]) begin
              operand <= oper2_i;
              acc     <= {{WIDTH{1'b0}}, oper1_i};
            end else begin
              operand <= oper1_i;
              acc     <= {{WIDTH{1'b0}}, oper2_i};
            end
            if (div_zero) result_o <= op_i[0] ? oper1_i : '1;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= last ? '0 : count + CW'(1);
          // Low half: product low / quotient; high half: product high / remainder.
          if (last) result_o <= op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed and random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] oper1_i = '0;
  logic [W-1:0] oper2_i = '0;
  logic         flush_i = 1'b0;
  logic         ready_o, stall_o, done_o;
  logic [W-1:0] result_o;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .oper1_i(oper1_i), .oper2_i(oper2_i), .flush_i(flush_i),
    .ready_o(ready_o), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_res = '0;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done_o=1 expected none (cycle %0d)", cycle);
        end else begin
          e = q.pop_front();
          check("result", result_o, e.res);
          check("latency", W'(cycle), W'(e.cyc));
          check("stall_in_done", {31'b0, stall_o}, 32'd0);
        end
      end else if (q.size() > 0 && cycle > q[0].cyc) begin
        e = q.pop_front();
        tests++; fails++;
        $display("FAIL missing_done: got no done_o expected at cycle %0d (now %0d)", e.cyc, cycle);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1");
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    exp_t e;
    wait_ready();
    start_i = 1'b1; op_i = op; oper1_i = a; oper2_i = b;
    #1;
    check("stall_on_request", {31'b0, stall_o}, 32'd1);
    if (track) begin
      e.res = model(op, a, b);
      e.cyc = cycle + ((op[1] && b == 0) ? 1 : W + 1);
      q.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    start_i = 1'b0; op_i = 2'($urandom); oper1_i = $urandom; oper2_i = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back as soon as ready
    issue(2'd0, 32'd7, 32'd6, 1);
    @(negedge clk);
    check("stall_in_run", {31'b0, stall_o}, 32'd1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(2'd2, 32'd100, 32'd7, 1);
    issue(2'd3, 32'd100, 32'd7, 1);
    issue(2'd2, 32'd5, 32'd0, 1);
    issue(2'd3, 32'd5, 32'd0, 1);
    issue(2'd0, 32'd0, 32'h1234_5678, 1);
    issue(2'd2, 32'd3, 32'd9, 1);
    issue(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    drain();

    // Flush wins over start in IDLE
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; oper1_i = 32'd2; oper2_i = 32'd2;
    #1;
    check("stall_flush_idle", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("ready_after_flush_idle", {31'b0, ready_o}, 32'd1);

    // Flush mid-RUN with start held throughout
    wait_ready();
    start_i = 1'b1; op_i = 2'd0; oper1_i = 32'd11; oper2_i = 32'd13;
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    check("ready_after_flush", {31'b0, ready_o}, 32'd1);
    check("result_kept_flush", result_o, last_res);
    repeat (40) @(negedge clk);
    check("result_kept_later", result_o, last_res);

    // Asynchronous reset mid-RUN
    issue(2'd0, 32'd123, 32'd456, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'b0, ready_o}, 32'd1);
    check("arst_stall", {31'b0, stall_o}, 32'd0);
    check("arst_done", {31'b0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 32'd3, 32'd3, 1);
    drain();

    // Random operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      issue(op, a, b, 1);
    end
    drain();
    repeat (5) @(negedge clk);
    check("queue_empty", W'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
